axis_memory_controller: RTL and testbench



---
 rtl/axis_memory_controller.sv | 102 ++++++++++
 tb/tb_axis_memory_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_memory_controller.sv
`default_nettype none
// ============================================================================
//  Module   : axis_memory_controller
//  Purpose  : AXI-Stream store-and-forward buffer. Accepted slave words
//             {tlast, tstrb, tdata} are written into MEM_SIZE entries and
//             returned in arrival order on the master port. The master port
//             is first-word fall-through.
//  Options  : MEMCTRL_STRB_MASK_EN - when defined, data bytes whose strobe
//             bit is 0 are stored as 0x00. The strobe bits are still stored.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_memory_controller #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  input  logic                    m01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast
);

  localparam int c_strb_width  = DATA_WIDTH / 8;
  localparam int c_entry_width = DATA_WIDTH + c_strb_width + 1;
  localparam logic [ADDR_WIDTH:0] c_full = (ADDR_WIDTH + 1)'(MEM_SIZE);

  // Storage is deliberately left out of reset; reset only discards contents
  logic [c_entry_width-1:0] r_mem [MEM_SIZE];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                     w_wr_en;
  logic                     w_rd_en;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [c_entry_width-1:0] w_head;

  // Flags come only from registered occupancy (and reset), never from tvalid/tready inputs
  assign s01_axis_tready = !axis_areset && (r_count != c_full);
  assign m01_axis_tvalid = (r_count != '0);

  assign w_wr_en = s01_axis_tvalid && s01_axis_tready;
  assign w_rd_en = m01_axis_tvalid && m01_axis_tready;

  // Data written to storage, optionally with unstrobed bytes zeroed
  always_comb begin
    w_wr_data = s01_axis_tdata;
`ifdef MEMCTRL_STRB_MASK_EN
    for (int b = 0; b < c_strb_width; b++) begin
      if (!s01_axis_tstrb[b]) begin
        w_wr_data[8*b +: 8] = 8'h00;
      end
    end
`endif
  end

  // Storage write port: one entry per accepted slave beat
  always_ff @(posedge axis_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {s01_axis_tlast, s01_axis_tstrb, w_wr_data};
    end
  end

  // Pointers and occupancy; a simultaneous read and write leaves count unchanged
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + (ADDR_WIDTH + 1)'(1);
      end else if (!w_wr_en && w_rd_en) begin
        r_count <= r_count - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Head entry read combinationally (fall-through), zeroed while nothing is buffered
  assign w_head = m01_axis_tvalid ? r_mem[r_rd_ptr] : '0;

  assign m01_axis_tlast = w_head[c_entry_width-1];
  assign m01_axis_tstrb = w_head[DATA_WIDTH +: c_strb_width];
  assign m01_axis_tdata = w_head[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_axis_memory_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_memory_controller
//  Purpose  : Self-checking bench for axis_memory_controller. A queue holds
//             the words the buffer should contain; every cycle the DUT
//             outputs are compared against the head of that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_memory_controller;

  localparam int MEM_SIZE   = 4096;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int SW         = DATA_WIDTH / 8;
  localparam int EW         = DATA_WIDTH + SW + 1;
`ifdef MEMCTRL_STRB_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [DATA_WIDTH-1:0] s_tdata  = '0;
  logic [SW-1:0]         s_tstrb  = '0;
  logic                  s_tvalid = 1'b1;
  logic                  s_tlast  = 1'b0;
  logic                  s_tready;
  logic                  m_tready = 1'b0;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic [SW-1:0]         m_tstrb;
  logic                  m_tvalid;
  logic                  m_tlast;

  int checks = 0;
  int errors = 0;

  // Expected buffer contents, oldest first, packed {last, strb, data}
  logic [EW-1:0] model_q[$];

  always #5 clk = ~clk;

  axis_memory_controller #(
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .axis_aclk      (clk),
    .axis_areset    (rst),
    .s01_axis_tdata (s_tdata),
    .s01_axis_tstrb (s_tstrb),
    .s01_axis_tvalid(s_tvalid),
    .s01_axis_tlast (s_tlast),
    .s01_axis_tready(s_tready),
    .m01_axis_tready(m_tready),
    .m01_axis_tdata (m_tdata),
    .m01_axis_tstrb (m_tstrb),
    .m01_axis_tvalid(m_tvalid),
    .m01_axis_tlast (m_tlast)
  );

  // Data value the buffer is expected to hold for a written word
  function automatic logic [DATA_WIDTH-1:0] stored_data(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [SW-1:0] s);
    logic [DATA_WIDTH-1:0] masked;
    masked = d;
    for (int b = 0; b < SW; b++) begin
      if (!s[b]) masked[8*b +: 8] = 8'h00;
    end
    return MASK_EN ? masked : d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the reference queue
  task automatic check_outputs(input string tag);
    logic [EW-1:0] h;
    h = (model_q.size() != 0) ? model_q[0] : '0;
    check({tag, " s_tready"}, 64'(s_tready), 64'(!rst && model_q.size() < MEM_SIZE));
    check({tag, " m_tvalid"}, 64'(m_tvalid), 64'(model_q.size() != 0));
    check({tag, " m_tdata"},  64'(m_tdata),  64'(h[DATA_WIDTH-1:0]));
    check({tag, " m_tstrb"},  64'(m_tstrb),  64'(h[DATA_WIDTH +: SW]));
    check({tag, " m_tlast"},  64'(m_tlast),  64'(h[EW-1]));
  endtask

  // One clock: drive at the falling edge, advance model at the rising edge, check at the next falling edge
  task automatic cycle(input logic v, input logic [DATA_WIDTH-1:0] d, input logic [SW-1:0] st,
                       input logic l, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = l;
    m_tready = r;
    @(posedge clk);
    if (!rst) begin
      bit wr;
      bit rd;
      wr = v && (model_q.size() < MEM_SIZE);
      rd = r && (model_q.size() != 0);
      if (rd) void'(model_q.pop_front());
      if (wr) model_q.push_back({l, st, stored_data(d, st)});
    end
    @(negedge clk);
    check_outputs("model");
  endtask

  typedef struct {
    logic                  v;
    logic [DATA_WIDTH-1:0] d;
    logic [SW-1:0]         st;
    logic                  l;
    logic                  r;
    logic                  ev;
    logic [DATA_WIDTH-1:0] ed;
    logic [SW-1:0]         es;
    logic                  el;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int accepted;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] d;

    // Directed vectors, starting from an empty buffer; expectations are after the edge
    vecs[0] = '{1'b1, 32'h0000_0055, 4'h1, 1'b1, 1'b0, 1'b1, 32'h0000_0055, 4'h1, 1'b1};
    vecs[1] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0055, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 4'hF, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0022, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0024, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0000_0022, 4'hF, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0024, 4'hF, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
    vecs[7] = '{1'b1, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 1'b1,
                (MASK_EN ? 32'h00BB_00DD : 32'hAABB_CCDD), 4'h5, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 1'b0};

    // Reset held with the producer offering a word
    @(negedge clk);
    check("rst s_tready", 64'(s_tready), 64'd0);
    check("rst m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst m_tdata",  64'(m_tdata),  64'd0);
    check("rst m_tstrb",  64'(m_tstrb),  64'd0);
    check("rst m_tlast",  64'(m_tlast),  64'd0);
    rst = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("post-rst s_tready", 64'(s_tready), 64'd1);

    // Table-driven directed vectors
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].st, vecs[i].l, vecs[i].r);
      check($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].ev));
      check($sformatf("vec%0d m_tdata", i),  64'(m_tdata),  64'(vecs[i].ed));
      check($sformatf("vec%0d m_tstrb", i),  64'(m_tstrb),  64'(vecs[i].es));
      check($sformatf("vec%0d m_tlast", i),  64'(m_tlast),  64'(vecs[i].el));
    end

    // Fill to full with a stalled consumer
    accepted = 0;
    for (int i = 0; i < MEM_SIZE + 8; i++) begin
      if (s_tready) accepted++;
      cycle(1'b1, 32'(i), 4'hF, 1'(i % 2), 1'b0);
    end
    check("full accepted", 64'(accepted), 64'(MEM_SIZE));
    check("full s_tready", 64'(s_tready), 64'd0);
    check("full head", 64'(m_tdata), 64'd0);
    // One read frees an entry; tready rises the next cycle
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("after read s_tready", 64'(s_tready), 64'd1);
    check("after read head", 64'(m_tdata), 64'd1);
    // Write through the wrapped pointer, then drain everything in order
    cycle(1'b1, 32'hCAFE_0000, 4'hF, 1'b1, 1'b0);
    check("refull s_tready", 64'(s_tready), 64'd0);
    for (int i = 0; i < MEM_SIZE + 4; i++) begin
      if (model_q.size() == 1) check("wrap word", 64'(m_tdata), 64'h0000_0000_CAFE_0000);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
    end
    check("drained m_tvalid", 64'(m_tvalid), 64'd0);

    // Pass-through at an occupancy of one
    prev = 32'h1234_5678;
    cycle(1'b1, prev, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      check("pass m_tvalid", 64'(m_tvalid), 64'd1);
      check("pass m_tdata", 64'(m_tdata), 64'(prev));
      cycle(1'b1, d, 4'hF, 1'b0, 1'b1);
      prev = d;
    end

    // Randomised traffic: first filling-biased, then draining-biased
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 1'($urandom),
            (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    if (model_q.size() == 0) cycle(1'b1, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a transfer
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst s_tready", 64'(s_tready), 64'd0);
    check("midrst m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst m_tdata",  64'(m_tdata),  64'd0);
    check("midrst m_tstrb",  64'(m_tstrb),  64'd0);
    check("midrst m_tlast",  64'(m_tlast),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    #1;
    check("midrst release s_tready", 64'(s_tready), 64'd1);
    check("midrst release m_tvalid", 64'(m_tvalid), 64'd0);

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1) != 0, $urandom, 4'($urandom), 1'($urandom),
            $urandom_range(0, 1) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
